// File: rtl/mont_enc.sv
// mont_enc: maps an operand a < q into the Montgomery domain, a*2^R_BITS mod q,
// with one doubling/conditional-subtract step per clock. Macro MONT_ENC_PREREDUCE_EN adds a PRE stage.
module mont_enc #(
  parameter int K      = 54,
  parameter int W      = 24,
  parameter int M      = 17,
  parameter int R_BITS = 3*W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [K-1:0] in_data,
  input  logic [M-1:0] q_m,
  input  logic [3:0]   current_k,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [K-1:0] out_data,
  output logic         busy
);

  localparam int TW = K - M - W;
  localparam int CW = $clog2(R_BITS + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(R_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state;
  logic [K-1:0]    r_t;
  logic [M-1:0]    r_qm;
  logic [3:0]      r_k;
  logic [CW-1:0]   r_cnt;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_busy;

  logic [TW-1:0]   w_top;
  logic [K-1:0]    w_q;
  logic [K:0]      w_d;
  logic [K+1:0]    w_s;
  logic            w_keep_d;
  logic [K-1:0]    w_step;

  // Modulus is rebuilt from the captured segment and size, never from the live inputs
  assign w_top = {TW{1'b1}} >> (4'd8 - r_k);
  assign w_q   = {w_top, r_qm, {(W-1){1'b0}}, 1'b1};

  assign w_d      = {r_t, 1'b0};
  assign w_s      = {1'b0, w_d} - {2'b00, w_q};
  // With T < q a negative S also sets bit K, so either bit selects the unsubtracted value
  assign w_keep_d = w_s[K+1] | w_s[K];
  assign w_step   = w_keep_d ? w_d[K-1:0] : w_s[K-1:0];

`ifdef MONT_ENC_PREREDUCE_EN
  logic [K:0]   w_p;
  logic [K-1:0] w_pre;
  assign w_p   = {1'b0, r_t} - {1'b0, w_q};
  assign w_pre = w_p[K] ? r_t : w_p[K-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_t         <= '0;
      r_qm        <= '0;
      r_k         <= 4'd0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_t        <= in_data;
            r_qm       <= q_m;
            r_k        <= current_k;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
`ifdef MONT_ENC_PREREDUCE_EN
            r_state    <= S_PRE;
`else
            r_state    <= S_RUN;
`endif
          end
        end
`ifdef MONT_ENC_PREREDUCE_EN
        S_PRE: begin
          r_t     <= w_pre;
          r_state <= S_RUN;
        end
`endif
        S_RUN: begin
          r_t   <= w_step;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST_STEP) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign out_data  = r_t;

endmodule

// File: tb/tb_mont_enc.sv
// tb_mont_enc: directed and random checks of mont_enc against a wide-modulo golden value
// and a bit-serial Montgomery reduction round trip; a second instance uses R_BITS=1.
module tb_mont_enc;
  localparam int K  = 54;
  localparam int W  = 24;
  localparam int M  = 17;
  localparam int RB = 72;
`ifdef MONT_ENC_PREREDUCE_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [K-1:0] in_data, out_data;
  logic [M-1:0] q_m;
  logic [3:0]   current_k;
  logic         in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic [K-1:0] in_data1, out_data1;

  int n_vec = 0;
  int n_err = 0;

  mont_enc #(.K(K), .W(W), .M(M), .R_BITS(RB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .q_m(q_m), .current_k(current_k), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy));

  mont_enc #(.K(K), .W(W), .M(M), .R_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .q_m(q_m), .current_k(current_k), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1), .busy(busy1));

  function automatic logic [K-1:0] mkq(input logic [M-1:0] qm, input logic [3:0] k);
    logic [12:0] top;
    top = 13'h1fff >> (4'd8 - k);
    return {top, qm, 23'd0, 1'b1};
  endfunction

  function automatic logic [K-1:0] golden(input logic [K-1:0] a, input logic [K-1:0] q);
    logic [127:0] x;
    logic [127:0] m;
    x = {2'b00, a, 72'd0};
    m = {74'd0, q};
    x = x % m;
    return x[K-1:0];
  endfunction

  // Bit-serial reduction t*2^-72 mod q, i.e. multiply by 1 then Montgomery-reduce
  function automatic logic [K-1:0] redc(input logic [K-1:0] t, input logic [K-1:0] q);
    logic [K+1:0] u;
    u = {2'b00, t};
    for (int i = 0; i < RB; i++) begin
      if (u[0]) u = u + {2'b00, q};
      u = u >> 1;
    end
    if (u >= {2'b00, q}) u = u - {2'b00, q};
    return u[K-1:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int lat, input bit scramble);
    lat = 0;
    while (!out_valid && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
      if (scramble) begin
        q_m       = 17'($urandom);
        current_k = 4'($urandom_range(0, 8));
        in_data   = 54'({$urandom, $urandom});
      end
    end
  endtask

  task automatic run_op(input logic [K-1:0] a, input logic [M-1:0] qm, input logic [3:0] k,
                        input bit scramble, output logic [K-1:0] res, output int lat);
    int g;
    @(negedge clk);
    in_data = a; q_m = qm; current_k = k; in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("accept_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_done(lat, scramble);
    res = out_data;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic full_check(input string tag, input logic [K-1:0] a, input logic [M-1:0] qm,
                            input logic [3:0] k, input bit scramble);
    logic [K-1:0] res;
    logic [K-1:0] q;
    int lat;
    q = mkq(qm, k);
    run_op(a, qm, k, scramble, res, lat);
    check({tag, "_data"}, 64'(res), 64'(golden(a, q)));
    check({tag, "_lat"}, 64'(lat), 64'(RB + EXTRA));
    check({tag, "_rtrip"}, 64'(redc(res, q)), 64'(a));
  endtask

  initial begin
    logic [K-1:0] q8, q, a1, a2, res;
    logic [M-1:0] qm;
    logic [3:0]   k;
    int lat;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; q_m = '0; current_k = 4'd8;
    in_valid1 = 1'b0; out_ready1 = 1'b0; in_data1 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);

    q8 = mkq(17'd0, 4'd8);
    full_check("a0", 54'd0, 17'd0, 4'd8, 1'b0);
    full_check("a1", 54'd1, 17'd0, 4'd8, 1'b0);
    full_check("aqm1", q8 - 54'd1, 17'd0, 4'd8, 1'b0);
    full_check("k0", mkq(17'h1abcd, 4'd0) - 54'd1, 17'h1abcd, 4'd0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      qm = 17'($urandom);
      k  = 4'($urandom_range(0, 8));
      q  = mkq(qm, k);
      a1 = 54'({$urandom, $urandom} % {10'd0, q});
      full_check("rand", a1, qm, k, 1'b0);
    end

    // Inputs scrambled after accept must not disturb the result
    full_check("scramble", 54'h123456789, 17'h0f0f0, 4'd5, 1'b1);

    // Back-pressure with a second operand already waiting
    q  = mkq(17'h15555, 4'd7);
    a1 = q - 54'd3;
    a2 = 54'h2468ace;
    @(negedge clk);
    in_data = a1; q_m = 17'h15555; current_k = 4'd7; in_valid = 1'b1;
    @(posedge clk);
    #1 in_data = a2;
    wait_done(lat, 1'b0);
    check("bp_lat", 64'(lat), 64'(RB + EXTRA));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_hold", 64'(out_data), 64'(golden(a1, q)));
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("bp_idle_ready", 64'(in_ready), 64'd1);
    check("bp_idle_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("b2b_busy", 64'(busy), 64'd1);
    wait_done(lat, 1'b0);
    check("b2b_lat", 64'(lat), 64'(RB + EXTRA));
    check("b2b_data", 64'(out_data), 64'(golden(a2, q)));
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;

    // Reset in the middle of a run discards the operation
    @(negedge clk);
    in_data = q8 - 54'd7; q_m = 17'd0; current_k = 4'd8; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("mrst_in_ready", 64'(in_ready), 64'd1);
    check("mrst_out_valid", 64'(out_valid), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_out_data", 64'(out_data), 64'd0);
    full_check("after_rst", 54'h3fffffffff, 17'h00abc, 4'd6, 1'b1);

    // R_BITS=1 instance: one doubling of q-1 gives q-2
    @(negedge clk);
    q_m = 17'd0; current_k = 4'd8; in_data1 = q8 - 54'd1; in_valid1 = 1'b1;
    @(posedge clk);
    #1 in_valid1 = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    check("r1_lat", 64'(lat), 64'(1 + EXTRA));
    check("r1_data", 64'(out_data1), 64'(q8 - 54'd2));
    out_ready1 = 1'b1;
    @(posedge clk);
    #1 out_ready1 = 1'b0;
`ifdef MONT_ENC_PREREDUCE_EN
    @(negedge clk);
    in_data1 = q8 + 54'd5; in_valid1 = 1'b1;
    @(posedge clk);
    #1 in_valid1 = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    check("r1_pre_data", 64'(out_data1), 64'd10);
    out_ready1 = 1'b1;
    @(posedge clk);
    #1 out_ready1 = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
